// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
// Shares one registered ALU between two requesters. Round-robin grant in IDLE,
// drives registered operands/select to the ALU, waits out the ALU latency,
// captures result and zero flag, and returns them over a valid/ready channel.
// One operation in flight at a time.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   reqN_valid/ready/op/a/b       requester N (N = 0, 1); ready is combinational
//   resp_valid/ready              response handshake (resp_valid registered)
//   resp_id/data/zero/err         response owner, ALU result, zero flag, bad op
//   alu_a, alu_b, alu_sel         registered operands and select to the ALU
//   alu_out, alu_z                ALU result and zero flag
//   busy                          high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
    parameter int DW      = 16,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [2:0]    req0_op,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [2:0]    req1_op,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_id,
    output logic [DW-1:0] resp_data,
    output logic          resp_zero,
    output logic          resp_err,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_sel,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_z,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        CAPT = 2'b10,
        RESP = 2'b11
    } state_e;

    // Counter start value: EXEC lasts ALU_LAT cycles (1..4).
    localparam logic [1:0] CNT_INIT = 2'(ALU_LAT - 1);
    localparam logic [2:0] SEL_PASS_A = 3'b011;

    // Opcodes 000..100 exist in the ALU; 101..111 are rejected.
    function automatic logic op_legal(input logic [2:0] op);
        return (op <= 3'b100);
    endfunction

    state_e        state_q, state_d;
    logic          rr_q, rr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          id_q, id_d;
    logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]    alu_sel_q, alu_sel_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_id_q, resp_id_d;
    logic [DW-1:0] resp_data_q, resp_data_d;
    logic          resp_zero_q, resp_zero_d;
    logic          resp_err_q, resp_err_d;
    logic          busy_q, busy_d;

    logic          gnt1_s;
    logic          accept_s;
    logic [2:0]    sel_op_s;
    logic [DW-1:0] sel_a_s, sel_b_s;

    // Grant selection: a lone requester wins, otherwise the round-robin pointer.
    always_comb begin
        gnt1_s     = req1_valid && (!req0_valid || rr_q);
        accept_s   = (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept_s && !gnt1_s;
        req1_ready = accept_s && gnt1_s;
        sel_op_s   = gnt1_s ? req1_op : req0_op;
        sel_a_s    = gnt1_s ? req1_a  : req0_a;
        sel_b_s    = gnt1_s ? req1_b  : req0_b;
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        resp_zero_d = resp_zero_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    id_d = gnt1_s;
                    if (op_legal(sel_op_s)) begin
                        alu_sel_d = sel_op_s;
                        alu_a_d   = sel_a_s;
                        alu_b_d   = sel_b_s;
                        cnt_d     = CNT_INIT;
                        state_d   = EXEC;
                    end else begin
                        // Bad opcode never reaches the ALU; answer straight away.
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                        resp_zero_d = 1'b0;
                        resp_id_d   = gnt1_s;
                        state_d     = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == 2'd0) begin
                    state_d = CAPT;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            CAPT: begin
                resp_data_d = alu_out;
                resp_zero_d = alu_z;
                resp_err_d  = 1'b0;
                resp_id_d   = id_q;
                state_d     = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    rr_d    = ~resp_id_q;
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered status outputs follow the state being entered.
        resp_valid_d = (state_d == RESP);
        busy_d       = (state_d != IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            cnt_q        <= 2'd0;
            id_q         <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= SEL_PASS_A;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_zero_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_zero_q  <= resp_zero_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_zero  = resp_zero_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

endmodule
